// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage core's pipeline sequencing control:
// controller state encoding, drain length, register-address width and the
// bubble-counter width, plus a saturating increment used by the counter.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Cycles after HALT enters ID/EX before the pipe is empty (EX, MEM, WB).
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam int REG_AW       = 3;
  localparam int STALL_CNT_W  = 16;

  localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE    = STALL_CNT_W'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational read-after-write check of the ID instruction's sources
// (rs, rt) against the older writers in ID/EX and EX/MEM. WB is not compared
// because the register file bypasses a same-cycle write to the read port.
// Ports:
//   id_rs_i, id_rt_i         source addresses of the ID instruction
//   id_rs_vld_i, id_rt_vld_i the ID instruction really reads that source
//   ex_write_reg_i, ex_regwrt_i, ex_nop_i     destination info held in ID/EX
//   mem_write_reg_i, mem_regwrt_i, mem_nop_i  destination info held in EX/MEM
//   raw_hit_o                any valid source matches a live older writer
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module hazard_detect (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_vld_i,
  input  logic              id_rt_vld_i,
  input  logic [REG_AW-1:0] ex_write_reg_i,
  input  logic              ex_regwrt_i,
  input  logic              ex_nop_i,
  input  logic [REG_AW-1:0] mem_write_reg_i,
  input  logic              mem_regwrt_i,
  input  logic              mem_nop_i,
  output logic              raw_hit_o
);

  logic ex_live;
  logic mem_live;
  logic rs_hit;
  logic rt_hit;

  // A bubble may still carry a stale destination field; only real writers count.
  assign ex_live  = ex_regwrt_i & ~ex_nop_i;
  assign mem_live = mem_regwrt_i & ~mem_nop_i;

  assign rs_hit = id_rs_vld_i &
                  ((ex_live  & (id_rs_i == ex_write_reg_i)) |
                   (mem_live & (id_rs_i == mem_write_reg_i)));
  assign rt_hit = id_rt_vld_i &
                  ((ex_live  & (id_rt_i == ex_write_reg_i)) |
                   (mem_live & (id_rt_i == mem_write_reg_i)));

  assign raw_hit_o = rs_hit | rt_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller. Each cycle decides whether IF/ID and ID/EX
// advance, hold or take a bubble, covering RAW hazards, EX-resolved redirects,
// data-memory busy freezes and HALT draining.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   id_rs/id_rt(+_vld)       ID sources;  id_halt: ID holds HALT
//   ex_write_reg/regwrt/nop  ID/EX writer; mem_write_reg/regwrt/nop: EX/MEM writer
//   ex_redirect              taken branch/jump resolved in EX
//   mem_busy                 data memory not ready, whole pipe holds
//   pc_stall, ifid_stall, ifid_flush, idex_nop, pipe_freeze
//                            combinational controls sampled at the same edge
//   halted                   registered, pipe fully drained after HALT
//   stall_cnt                registered saturating count of RAW/redirect bubbles
// All outputs read 0 while rst is high.
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module pipe_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_rs_vld,
  input  logic                   id_rt_vld,
  input  logic                   id_halt,
  input  logic [REG_AW-1:0]      ex_write_reg,
  input  logic                   ex_regwrt,
  input  logic                   ex_nop,
  input  logic [REG_AW-1:0]      mem_write_reg,
  input  logic                   mem_regwrt,
  input  logic                   mem_nop,
  input  logic                   ex_redirect,
  input  logic                   mem_busy,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_nop,
  output logic                   pipe_freeze,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_e            state_q, state_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [STALL_CNT_W-1:0] cnt_q,   cnt_d;
  logic                   halted_q;

  logic raw_hit;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_nop_c, pipe_freeze_c;

  hazard_detect u_hazard (
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .id_rs_vld_i     (id_rs_vld),
    .id_rt_vld_i     (id_rt_vld),
    .ex_write_reg_i  (ex_write_reg),
    .ex_regwrt_i     (ex_regwrt),
    .ex_nop_i        (ex_nop),
    .mem_write_reg_i (mem_write_reg),
    .mem_regwrt_i    (mem_regwrt),
    .mem_nop_i       (mem_nop),
    .raw_hit_o       (raw_hit)
  );

  always_comb begin
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_nop_c    = 1'b0;
    pipe_freeze_c = 1'b0;
    state_d       = state_q;
    drain_d       = drain_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          pipe_freeze_c = 1'b1;
        end else if (ex_redirect) begin
          // Flushing IF/ID and bubbling ID/EX kills both wrong-path slots at
          // once; a HALT sitting in ID is squashed with them.
          ifid_flush_c = 1'b1;
          idex_nop_c   = 1'b1;
          cnt_d        = sat_inc(cnt_q);
        end else if (raw_hit) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_nop_c   = 1'b1;
          cnt_d        = sat_inc(cnt_q);
        end else if (id_halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end

      DRAIN: begin
        // Everything older than HALT is non-branching, so redirect and RAW
        // inputs are meaningless here and deliberately ignored.
        if (mem_busy) begin
          pipe_freeze_c = 1'b1;
        end else begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          idex_nop_c   = 1'b1;
          if (drain_q == '0) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q - DRAIN_ONE;
          end
        end
      end

      HALTED: begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_nop_c   = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      drain_q  <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Reset masks every output, including the registered ones before the
  // first reset edge has loaded them.
  assign pc_stall    = pc_stall_c    & ~rst;
  assign ifid_stall  = ifid_stall_c  & ~rst;
  assign ifid_flush  = ifid_flush_c  & ~rst;
  assign idex_nop    = idex_nop_c    & ~rst;
  assign pipe_freeze = pipe_freeze_c & ~rst;
  assign halted      = halted_q      & ~rst;
  assign stall_cnt   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed vectors for pipe_ctrl. The driver applies one vector per cycle and
// queues its hand-computed expected outputs; an independent monitor pops the
// queue on the falling edge and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_rs, id_rt;
  logic        id_rs_vld, id_rt_vld, id_halt;
  logic [2:0]  ex_write_reg;
  logic        ex_regwrt, ex_nop;
  logic [2:0]  mem_write_reg;
  logic        mem_regwrt, mem_nop;
  logic        ex_redirect, mem_busy;
  logic        pc_stall, ifid_stall, ifid_flush, idex_nop, pipe_freeze, halted;
  logic [15:0] stall_cnt;

  // flag order: {pc_stall, ifid_stall, ifid_flush, idex_nop, pipe_freeze, halted}
  typedef struct {
    string       name;
    logic [5:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [5:0] F_IDLE   = 6'b000000;
  localparam logic [5:0] F_RAW    = 6'b110100;
  localparam logic [5:0] F_REDIR  = 6'b001100;
  localparam logic [5:0] F_FREEZE = 6'b000010;
  localparam logic [5:0] F_DRAIN  = 6'b101100;
  localparam logic [5:0] F_HALTED = 6'b110101;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_vld     (id_rs_vld),
    .id_rt_vld     (id_rt_vld),
    .id_halt       (id_halt),
    .ex_write_reg  (ex_write_reg),
    .ex_regwrt     (ex_regwrt),
    .ex_nop        (ex_nop),
    .mem_write_reg (mem_write_reg),
    .mem_regwrt    (mem_regwrt),
    .mem_nop       (mem_nop),
    .ex_redirect   (ex_redirect),
    .mem_busy      (mem_busy),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .ifid_flush    (ifid_flush),
    .idex_nop      (idex_nop),
    .pipe_freeze   (pipe_freeze),
    .halted        (halted),
    .stall_cnt     (stall_cnt)
  );

  // Falling edge at 5, rising at 10: inputs driven just after a rising edge
  // are checked half a period later, before the next rising edge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        logic [5:0] act;
        e   = exp_q.pop_front();
        act = {pc_stall, ifid_stall, ifid_flush, idex_nop, pipe_freeze, halted};
        n_checks++;
        if (act !== e.flags || stall_cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL %s: got flags=%b cnt=%h, want flags=%b cnt=%h",
                   e.name, act, stall_cnt, e.flags, e.cnt);
        end
      end
    end
  end

  task automatic clr();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
    id_halt = 1'b0;
    ex_write_reg = 3'd0; ex_regwrt = 1'b0; ex_nop = 1'b0;
    mem_write_reg = 3'd0; mem_regwrt = 1'b0; mem_nop = 1'b0;
    ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  // Queue the expectation for the vector now on the inputs, then let one edge pass.
  task automatic step(input string name, input logic [5:0] flags, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.flags = flags; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Same as step but without a check, for long filler runs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raw_ex_rs3();
    id_rs = 3'd3; id_rs_vld = 1'b1; ex_write_reg = 3'd3; ex_regwrt = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    clr();
    rst = 1'b1;
    ex_redirect = 1'b1;
    step("reset_forces_zero", F_IDLE, 16'd0);
    clr(); mem_busy = 1'b1;
    step("reset_busy_zero", F_IDLE, 16'd0);
    rst = 1'b0; clr();
    step("after_reset_idle", F_IDLE, 16'd0);

    // RAW against EX, then the same producer in MEM, then release.
    clr(); raw_ex_rs3();
    step("raw_ex_stall", F_RAW, 16'd0);
    clr(); id_rs = 3'd3; id_rs_vld = 1'b1;
    ex_write_reg = 3'd3; ex_regwrt = 1'b1; ex_nop = 1'b1;
    mem_write_reg = 3'd3; mem_regwrt = 1'b1;
    step("raw_mem_stall", F_RAW, 16'd1);
    clr(); id_rs = 3'd3; id_rs_vld = 1'b1;
    mem_write_reg = 3'd3; mem_regwrt = 1'b1; mem_nop = 1'b1;
    step("raw_release", F_IDLE, 16'd2);

    // rt against MEM only.
    clr(); id_rt = 3'd5; id_rt_vld = 1'b1; mem_write_reg = 3'd5; mem_regwrt = 1'b1;
    step("raw_rt_mem", F_RAW, 16'd2);
    // Non-hits: source unused, producer is a bubble, producer does not write.
    clr(); id_rs = 3'd3; ex_write_reg = 3'd3; ex_regwrt = 1'b1;
    step("no_hit_rs_unused", F_IDLE, 16'd3);
    clr(); raw_ex_rs3(); ex_nop = 1'b1;
    step("no_hit_ex_bubble", F_IDLE, 16'd3);
    clr(); id_rt = 3'd4; id_rt_vld = 1'b1; mem_write_reg = 3'd4;
    step("no_hit_no_regwrt", F_IDLE, 16'd3);
    clr(); raw_ex_rs3(); ex_write_reg = 3'd2;
    step("no_hit_diff_reg", F_IDLE, 16'd3);

    // Redirect squashes a HALT in ID; pipe stays in RUN.
    clr(); ex_redirect = 1'b1; id_halt = 1'b1;
    step("redirect_squash_halt", F_REDIR, 16'd3);
    clr();
    step("run_after_squash", F_IDLE, 16'd4);

    // Freeze beats redirect and RAW; the redirect is re-presented.
    clr(); mem_busy = 1'b1; ex_redirect = 1'b1; raw_ex_rs3();
    step("busy_wins", F_FREEZE, 16'd4);
    clr(); ex_redirect = 1'b1;
    step("redirect_repeat", F_REDIR, 16'd4);
    clr(); ex_redirect = 1'b1; raw_ex_rs3();
    step("redirect_over_raw", F_REDIR, 16'd5);

    // HALT: entry edge 1, drain edges 2,5,6 with two frozen cycles between.
    clr(); id_halt = 1'b1;
    step("halt_advances", F_IDLE, 16'd6);
    clr(); ex_redirect = 1'b1; raw_ex_rs3(); id_halt = 1'b1;
    step("drain_ignores_inputs", F_DRAIN, 16'd6);
    clr(); mem_busy = 1'b1;
    step("drain_frozen_1", F_FREEZE, 16'd6);
    step("drain_frozen_2", F_FREEZE, 16'd6);
    clr();
    step("drain_cnt1", F_DRAIN, 16'd6);
    step("drain_cnt0", F_DRAIN, 16'd6);
    mem_busy = 1'b1; ex_redirect = 1'b1;
    step("halted_rises", F_HALTED, 16'd6);
    clr(); raw_ex_rs3();
    step("halted_stays", F_HALTED, 16'd6);

    // Reset out of HALTED.
    rst = 1'b1; clr(); ex_redirect = 1'b1;
    step("rst_in_halted", F_IDLE, 16'd0);
    rst = 1'b0; clr();
    step("run_after_rst", F_IDLE, 16'd0);
    clr(); raw_ex_rs3();
    step("raw_after_rst", F_RAW, 16'd0);

    // Long redirect run to reach saturation.
    clr(); ex_redirect = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      exp_cnt = (1 + k > 65535) ? 65535 : 1 + k;
      if (k < 3 || k > 65530) step("sat_run", F_REDIR, 16'(exp_cnt));
      else tick();
    end
    clr();
    step("sat_hold", F_IDLE, 16'hFFFF);
    clr(); ex_redirect = 1'b1;
    step("sat_redirect", F_REDIR, 16'hFFFF);
    clr();
    step("sat_after", F_IDLE, 16'hFFFF);

    // Everything queued must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
